// File: rtl/hazard_sched_unit_if.sv
// Bus between the ID-stage hazard controller and the rest of the LEGv8 pipeline.
// The master drives the ID-stage fields and branch resolution; the slave returns the hazard controls.
interface hazard_sched_unit_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [10:0]      id_opcode;
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic [4:0]       id_rt;
  logic             mem_branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush_ifid;
  logic             flush_idex;
  logic             flush_exmem;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rn, id_rm, id_rt, mem_branch_taken,
    input  pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rn, id_rm, id_rt, mem_branch_taken,
    output pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sched_unit.sv
// Hazard controller for the 5-stage LEGv8 pipeline: load-use stalls, branch flushes,
// EX operand forwarding, and saturating stall/flush event counters.
module hazard_sched_unit #(
  parameter logic [4:0] XZR   = 5'd31,
  parameter int         CNT_W = 16
) (
  input logic                clk,
  input logic                reset_n,
  hazard_sched_unit_if.slave bus
);
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       regwrite;
    logic       memread;
    logic [4:0] src_a;
    logic [4:0] src_b;
  } sb_entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: XZR, regwrite: 1'b0,
                                     memread: 1'b0, src_a: XZR, src_b: XZR};

  state_e           state_q;
  sb_entry_t        ex_q, mem_q, wb_q;
  sb_entry_t        id_entry, ex_d, mem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use, flush_now, stall;
  logic [9:0]       ex_srcs;
  logic [3:0]       fwd_all;

  always_comb begin
    id_entry = SB_EMPTY;
    if (bus.id_valid) begin
      if (bus.id_opcode == OP_LDUR) begin
        id_entry.valid    = 1'b1;
        id_entry.src_a    = bus.id_rn;
        id_entry.dest     = bus.id_rt;
        id_entry.regwrite = 1'b1;
        id_entry.memread  = 1'b1;
      end else if (bus.id_opcode == OP_ADD || bus.id_opcode == OP_AND ||
                   bus.id_opcode == OP_ORR || bus.id_opcode == OP_SUB) begin
        id_entry.valid    = 1'b1;
        id_entry.src_a    = bus.id_rn;
        id_entry.src_b    = bus.id_rm;
        id_entry.dest     = bus.id_rt;
        id_entry.regwrite = 1'b1;
      end else if (bus.id_opcode == OP_STUR) begin
        id_entry.valid = 1'b1;
        id_entry.src_a = bus.id_rn;
        id_entry.src_b = bus.id_rt;
      end else if (bus.id_opcode[10:3] == OP_CBZ) begin
        // CBZ tests Rt through the ALU's second operand
        id_entry.valid = 1'b1;
        id_entry.src_b = bus.id_rt;
      end
    end
  end

  // ID sources that are XZR never match because the EX dest is required to be non-XZR
  assign load_use  = ex_q.valid && ex_q.memread && (ex_q.dest != XZR) &&
                     ((ex_q.dest == id_entry.src_a) || (ex_q.dest == id_entry.src_b));
  assign flush_now = (state_q == RUN) && bus.mem_branch_taken;
  assign stall     = load_use && (state_q == RUN) && !flush_now;

  always_comb begin
    ex_d        = (stall || flush_now) ? SB_EMPTY : id_entry;
    mem_d       = flush_now ? SB_EMPTY : ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush_now && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      ex_q        <= SB_EMPTY;
      mem_q       <= SB_EMPTY;
      wb_q        <= SB_EMPTY;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN:     if (bus.mem_branch_taken) state_q <= FLUSH;
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_srcs = {ex_q.src_b, ex_q.src_a};

  // Operand 0 is fwd_a, operand 1 is fwd_b; the MEM-stage result is younger so it wins
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_all[2*gi +: 2] =
      (!reset_n || !ex_q.valid || (ex_srcs[5*gi +: 5] == XZR)) ? 2'b00 :
      (mem_q.valid && mem_q.regwrite && (mem_q.dest == ex_srcs[5*gi +: 5])) ? 2'b10 :
      (wb_q.valid && wb_q.regwrite && (wb_q.dest == ex_srcs[5*gi +: 5])) ? 2'b01 :
      2'b00;
  end

  assign bus.pc_write    = !(stall && reset_n);
  assign bus.ifid_write  = !(stall && reset_n);
  assign bus.idex_bubble = stall && reset_n;
  assign bus.flush_ifid  = flush_now && reset_n;
  assign bus.flush_idex  = flush_now && reset_n;
  assign bus.flush_exmem = flush_now && reset_n;
  assign bus.fwd_a       = fwd_all[1:0];
  assign bus.fwd_b       = fwd_all[3:2];
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.memread, wb_q.src_a, wb_q.src_b};
endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline hazard controller for the 5-stage LEGv8 core (IF/ID/EX/MEM/WB); sits beside the main decoder.
- Decodes the ID-stage opcode into an instruction class and keeps an internal scoreboard of in-flight EX/MEM/WB destinations.
- Drives load-use stalls, branch-taken flushes and EX-stage forwarding selects, and counts stall/flush cycles for performance checks.

Parameters:
- XZR, 31: register index that is never a hazard source or destination.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  11  instruction[31:21] in ID.
- id_rn  in  5  instruction[9:5].
- id_rm  in  5  instruction[20:16].
- id_rt  in  5  instruction[4:0]; this is the Rd/Rt field.
- mem_branch_taken  in  1  CBZ in MEM resolved as taken.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID register may load.
- idex_bubble  out  1  zero the control bits entering ID/EX.
- flush_ifid, flush_idex, flush_exmem  out  1 each  squash those pipeline registers.
- fwd_a, fwd_b  out  2 each  EX operand source select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Instruction classes:
  - LDUR 11111000010: sources Rn; destination Rt; memread.
  - R-type ADD 10001011000, AND 10001010000, ORR 10101010000, SUB 11001011000: sources Rn, Rm; destination Rd.
  - STUR 11111000000: sources Rn, Rt; no destination.
  - CBZ opcode[10:3] = 10110100: source Rt; no destination.
  - Any other opcode, or id_valid = 0: NOP with no sources and no destination.
- Scoreboard stages EX, MEM, WB each hold valid, dest, regwrite, memread, src_a, src_b. Every clock they shift ID->EX->MEM->WB. A bubble or flush loads the EX entry as invalid.
- A destination or source equal to XZR is treated as absent.
- Load-use hazard (combinational): EX entry is valid and memread, its dest is not XZR, and the dest equals any ID source. When set and no flush is active:
  - pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Exactly one cycle of stall; the next cycle re-evaluates against the bubble.
- Forwarding (combinational, computed from EX entry sources):
  - fwd_a = 10 if the MEM entry has regwrite and MEM.dest == EX.src_a (not XZR).
  - Else fwd_a = 01 if the WB entry matches the same way.
  - Else fwd_a = 00.
  - fwd_b uses the same rules on src_b. MEM always beats WB.
- FSM states: RUN, FLUSH.
  - RUN: mem_branch_taken = 1 in RUN asserts flush_ifid, flush_idex and flush_exmem in that same cycle, invalidates the EX and MEM scoreboard entries at the clock edge, and moves to FLUSH.
  - FLUSH lasts one cycle: load-use stall is suppressed, flushes are deasserted, and the FSM returns to RUN.
  - mem_branch_taken while already in FLUSH is ignored; it cannot occur architecturally, and the ignore rule is asserted in verification.
- Simultaneous branch-taken and load-use in the same cycle: the flush wins. pc_write = 1, no stall is counted, and the branch target is fetched.
- Counters:
  - stall_cnt increments on each stall cycle; flush_cnt increments on each RUN->FLUSH transition.
  - Both saturate at all-ones with no wrap.
- Reset (async, applies mid-stall or mid-flush) drives:
  - FSM = RUN, all scoreboard entries invalid, counters = 0.
  - pc_write = 1, ifid_write = 1, idex_bubble = 0, all flush outputs = 0, fwd_a = fwd_b = 00.
  - Outputs reflect this immediately while reset_n is low.
- Latency: stall, flush and fwd outputs are combinational from current inputs and state; scoreboard updates one cycle later.

Test Plan:
- Load-use stall: LDUR X2,[X1,#0] then ADD X3,X2,X4 -> one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1, and stall_cnt = 1. When the ADD later reaches EX, fwd_a = 01.
- Forwarding priority: ADD X5,X1,X1; SUB X5,X2,X2; AND X6,X5,X5 -> in AND's EX cycle, fwd_a = fwd_b = 10 (SUB result from MEM, not the ADD in WB).
- XZR exclusion: LDUR XZR,[X1,#0] then ADD X3,XZR,XZR -> no stall, and fwd_a = fwd_b = 00.
- Branch flush: mem_branch_taken pulse -> all three flush outputs = 1 for one cycle, flush_cnt = 1. A following LDUR->use pair that was invalidated by the flush causes no stall.
- Simultaneous events: LDUR in EX with a dependent instruction in ID while mem_branch_taken = 1 -> pc_write = 1, idex_bubble = 0, stall_cnt unchanged, flush_cnt +1.
- Reset mid-stall: drop reset_n during a stall cycle -> outputs go to reset values without waiting for a clock edge. After release, the formerly dependent sequence produces no stall, and counters read 0.
